// File: rtl/mem_tg2_seq_ctrl_if.sv
// rtl/mem_tg2_seq_ctrl_if.sv - CSR/TG2 signal bundle for the TG2 launch/monitor sequencer
interface mem_tg2_seq_ctrl_if #(
  parameter int NUM_CH    = 4,
  parameter int TMO_W     = 32,
  parameter int CLK_CNT_W = 64
);
  logic                 ctrl_wr;
  logic [NUM_CH-1:0]    ctrl_init_n;
  logic                 seq_mode;
  logic [TMO_W-1:0]     tmo_limit;
  logic [NUM_CH-1:0]    tg_done;
  logic [NUM_CH-1:0]    tg_pass;
  logic [NUM_CH-1:0]    tg_start;
  logic [NUM_CH-1:0]    tg_abort;
  logic [NUM_CH-1:0]    stat_pass;
  logic [NUM_CH-1:0]    stat_fail;
  logic [NUM_CH-1:0]    stat_timeout;
  logic [NUM_CH-1:0]    stat_active;
  logic [CLK_CNT_W-1:0] clk_count;

  modport master (
    output ctrl_wr, ctrl_init_n, seq_mode, tmo_limit, tg_done, tg_pass,
    input  tg_start, tg_abort, stat_pass, stat_fail, stat_timeout, stat_active, clk_count
  );

  modport slave (
    input  ctrl_wr, ctrl_init_n, seq_mode, tmo_limit, tg_done, tg_pass,
    output tg_start, tg_abort, stat_pass, stat_fail, stat_timeout, stat_active, clk_count
  );
endinterface

// File: rtl/mem_tg2_seq_ctrl.sv
// rtl/mem_tg2_seq_ctrl.sv - per-channel TG2 launch sequencer with watchdog and batch cycle counter
module mem_tg2_seq_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int TMO_W     = 32,
  parameter int CLK_CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_tg2_seq_ctrl_if.slave bus
);
  typedef enum logic {CH_IDLE = 1'b0, CH_ACTIVE = 1'b1} ch_state_t;

  ch_state_t            r_state [NUM_CH];
  ch_state_t            w_state_nxt [NUM_CH];
  logic [TMO_W-1:0]     r_timer [NUM_CH];
  logic [NUM_CH-1:0]    r_pending;
  logic [NUM_CH-1:0]    r_pass;
  logic [NUM_CH-1:0]    r_fail;
  logic [NUM_CH-1:0]    r_tmo;
  logic [NUM_CH-1:0]    r_start;
  logic [NUM_CH-1:0]    r_abort;
  logic                 r_mode;
  logic [CLK_CNT_W-1:0] r_clk_count;

  logic [NUM_CH-1:0]    w_active;
  logic [NUM_CH-1:0]    w_cap;
  logic [NUM_CH-1:0]    w_launch;
  logic [NUM_CH-1:0]    w_done;
  logic [NUM_CH-1:0]    w_tmo_hit;
  logic                 w_idle;
  logic                 w_batch_start;
  logic                 w_tmo_en;
  logic [TMO_W-1:0]     w_tmo_last;

  // Request capture and batch bookkeeping; a channel finishing this cycle still counts as active
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_active[ch] = (r_state[ch] == CH_ACTIVE);
    end
    w_cap         = bus.ctrl_wr ? (~bus.ctrl_init_n & ~w_active & ~r_pending) : '0;
    w_idle        = (r_pending == '0) && (w_active == '0);
    w_batch_start = w_idle && (w_cap != '0);
    w_tmo_en      = (bus.tmo_limit != '0);
    w_tmo_last    = bus.tmo_limit - TMO_W'(1);
  end

  // Launch select: parallel fires all pending, serial fires the lowest pending once nothing runs
  always_comb begin
    w_launch = '0;
    if (!r_mode) begin
      w_launch = r_pending;
    end else if (w_active == '0) begin
      for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
        if (r_pending[ch]) begin
          w_launch     = '0;
          w_launch[ch] = 1'b1;
        end
      end
    end
  end

  // Per-channel next state: done beats the watchdog when both land on the same cycle
  always_comb begin
    w_done    = '0;
    w_tmo_hit = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      case (r_state[ch])
        CH_IDLE: begin
          if (w_launch[ch]) w_state_nxt[ch] = CH_ACTIVE;
        end
        CH_ACTIVE: begin
          if (bus.tg_done[ch]) begin
            w_done[ch]      = 1'b1;
            w_state_nxt[ch] = CH_IDLE;
          end else if (w_tmo_en && (r_timer[ch] == w_tmo_last)) begin
            w_tmo_hit[ch]   = 1'b1;
            w_state_nxt[ch] = CH_IDLE;
          end
        end
        default: w_state_nxt[ch] = CH_IDLE;
      endcase
    end
  end

  // Channel state, watchdog timers, result flags and start/abort pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch] <= CH_IDLE;
        r_timer[ch] <= '0;
      end
      r_pending <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_tmo     <= '0;
      r_start   <= '0;
      r_abort   <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        if (w_launch[ch]) begin
          r_timer[ch] <= '0;
          r_pass[ch]  <= 1'b0;
          r_fail[ch]  <= 1'b0;
          r_tmo[ch]   <= 1'b0;
        end else begin
          if (w_active[ch]) r_timer[ch] <= r_timer[ch] + TMO_W'(1);
          if (w_done[ch]) begin
            r_pass[ch] <= bus.tg_pass[ch];
            r_fail[ch] <= ~bus.tg_pass[ch];
          end else if (w_tmo_hit[ch]) begin
            r_tmo[ch]  <= 1'b1;
            r_pass[ch] <= 1'b0;
            r_fail[ch] <= 1'b0;
          end
        end
      end
      r_pending <= (r_pending & ~w_launch) | w_cap;
      r_start   <= w_launch;
      r_abort   <= w_tmo_hit;
    end
  end

  // Batch mode latch and saturating batch cycle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_clk_count <= '0;
    end else if (w_batch_start) begin
      r_mode      <= bus.seq_mode;
      r_clk_count <= '0;
    end else if (!w_idle && (r_clk_count != '1)) begin
      r_clk_count <= r_clk_count + CLK_CNT_W'(1);
    end
  end

  assign bus.tg_start     = r_start;
  assign bus.tg_abort     = r_abort;
  assign bus.stat_pass    = r_pass;
  assign bus.stat_fail    = r_fail;
  assign bus.stat_timeout = r_tmo;
  assign bus.stat_active  = w_active;
  assign bus.clk_count    = r_clk_count;
endmodule

// File: tb/tb_mem_tg2_seq_ctrl.sv
// tb/tb_mem_tg2_seq_ctrl.sv - directed scoreboard bench for mem_tg2_seq_ctrl
module tb_mem_tg2_seq_ctrl;
  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  evt_t start_q[$];
  evt_t abort_q[$];

  mem_tg2_seq_ctrl_if #(.NUM_CH(4), .TMO_W(32), .CLK_CNT_W(64)) bus_m ();
  mem_tg2_seq_ctrl_if #(.NUM_CH(4), .TMO_W(32), .CLK_CNT_W(4))  bus_s ();

  mem_tg2_seq_ctrl #(.NUM_CH(4), .TMO_W(32), .CLK_CNT_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );

  mem_tg2_seq_ctrl #(.NUM_CH(4), .TMO_W(32), .CLK_CNT_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  assign bus_s.ctrl_wr     = bus_m.ctrl_wr;
  assign bus_s.ctrl_init_n = bus_m.ctrl_init_n;
  assign bus_s.seq_mode    = bus_m.seq_mode;
  assign bus_s.tmo_limit   = bus_m.tmo_limit;
  assign bus_s.tg_done     = bus_m.tg_done;
  assign bus_s.tg_pass     = bus_m.tg_pass;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic wr(input logic [3:0] n);
    bus_m.ctrl_wr     = 1'b1;
    bus_m.ctrl_init_n = n;
    tick(1);
    bus_m.ctrl_wr     = 1'b0;
    bus_m.ctrl_init_n = 4'hF;
  endtask

  task automatic done(input logic [3:0] d, input logic [3:0] p);
    bus_m.tg_done = d;
    bus_m.tg_pass = p;
    tick(1);
    bus_m.tg_done = 4'h0;
    bus_m.tg_pass = 4'h0;
  endtask

  // Scoreboard side: every start/abort pulse must match the next queued expectation
  always @(negedge clk) begin
    evt_t e;
    if (bus_m.tg_start != 4'h0) begin
      if (start_q.size() == 0) chk("unexpected_tg_start", 64'(bus_m.tg_start), 64'h0);
      else begin
        e = start_q.pop_front();
        chk("tg_start_cycle", 64'(cyc), 64'(e.cyc));
        chk("tg_start_mask", 64'(bus_m.tg_start), 64'(e.mask));
      end
    end
    if (bus_m.tg_abort != 4'h0) begin
      if (abort_q.size() == 0) chk("unexpected_tg_abort", 64'(bus_m.tg_abort), 64'h0);
      else begin
        e = abort_q.pop_front();
        chk("tg_abort_cycle", 64'(cyc), 64'(e.cyc));
        chk("tg_abort_mask", 64'(bus_m.tg_abort), 64'(e.mask));
      end
    end
  end

  initial begin
    int k;
    int s;
    int c;
    bus_m.ctrl_wr     = 1'b0;
    bus_m.ctrl_init_n = 4'hF;
    bus_m.seq_mode    = 1'b0;
    bus_m.tmo_limit   = 32'd0;
    bus_m.tg_done     = 4'h0;
    bus_m.tg_pass     = 4'h0;
    tick(3);
    chk("rst_active", 64'(bus_m.stat_active), 64'h0);
    chk("rst_pass", 64'(bus_m.stat_pass), 64'h0);
    chk("rst_fail", 64'(bus_m.stat_fail), 64'h0);
    chk("rst_timeout", 64'(bus_m.stat_timeout), 64'h0);
    chk("rst_clk_count", bus_m.clk_count, 64'h0);
    chk("rst_start_abort", 64'({bus_m.tg_start, bus_m.tg_abort}), 64'h0);
    rst_n = 1'b1;
    tick(1);

    // Parallel launch of all four channels
    k = cyc;
    start_q.push_back('{k + 2, 4'hF});
    wr(4'h0);
    tick(2);
    chk("par_active", 64'(bus_m.stat_active), 64'hF);
    chk("par_clk_count_run", bus_m.clk_count, 64'd2);
    tick(5);
    c = cyc;
    done(4'hF, 4'b1010);
    chk("par_pass", 64'(bus_m.stat_pass), 64'hA);
    chk("par_fail", 64'(bus_m.stat_fail), 64'h5);
    chk("par_active_clr", 64'(bus_m.stat_active), 64'h0);
    chk("par_timeout", 64'(bus_m.stat_timeout), 64'h0);
    tick(2);
    chk("par_clk_count_hold", bus_m.clk_count, 64'(c - k));
    chk("par_sat_count_hold", 64'(bus_s.clk_count), 64'(c - k));

    // Serial launch of ch0 then ch2; mode change mid-batch must not matter
    bus_m.seq_mode = 1'b1;
    k = cyc;
    start_q.push_back('{k + 2, 4'b0001});
    wr(4'b1010);
    bus_m.seq_mode = 1'b0;
    tick(3);
    chk("ser_one_active", 64'(bus_m.stat_active), 64'b0001);
    c = cyc;
    start_q.push_back('{c + 2, 4'b0100});
    done(4'b0001, 4'b0001);
    chk("ser_gap_active", 64'(bus_m.stat_active), 64'h0);
    chk("ser_pass_ch0", 64'(bus_m.stat_pass), 64'b1011);
    chk("ser_fail_ch0", 64'(bus_m.stat_fail), 64'b0100);
    tick(1);
    chk("ser_ch2_active", 64'(bus_m.stat_active), 64'b0100);
    chk("ser_ch2_fail_clr", 64'(bus_m.stat_fail), 64'h0);
    tick(2);
    done(4'b0100, 4'b0000);
    chk("ser_ch2_fail", 64'(bus_m.stat_fail), 64'b0100);
    chk("ser_idle", 64'(bus_m.stat_active), 64'h0);

    // Watchdog expiry on ch0 after 100 active cycles
    bus_m.tmo_limit = 32'd100;
    k = cyc;
    s = k + 2;
    start_q.push_back('{s, 4'b0001});
    abort_q.push_back('{s + 100, 4'b0001});
    wr(4'b1110);
    wait_until(s + 99);
    chk("tmo_still_active", 64'(bus_m.stat_active), 64'b0001);
    chk("tmo_not_yet", 64'(bus_m.stat_timeout), 64'h0);
    tick(1);
    chk("tmo_flag", 64'(bus_m.stat_timeout), 64'b0001);
    chk("tmo_active_clr", 64'(bus_m.stat_active), 64'h0);
    chk("tmo_pass", 64'(bus_m.stat_pass), 64'b1010);
    chk("tmo_fail", 64'(bus_m.stat_fail), 64'b0100);

    // Done on the last watchdog cycle wins over the timeout
    bus_m.tmo_limit = 32'd20;
    k = cyc;
    s = k + 2;
    start_q.push_back('{s, 4'b0010});
    wr(4'b1101);
    wait_until(s + 19);
    done(4'b0010, 4'b0010);
    chk("race_pass", 64'(bus_m.stat_pass), 64'b1010);
    chk("race_timeout", 64'(bus_m.stat_timeout), 64'b0001);
    chk("race_active", 64'(bus_m.stat_active), 64'h0);
    tick(3);

    // Watchdog disabled: long run, re-request ignored, counter saturation, write racing completion
    bus_m.tmo_limit = 32'd0;
    k = cyc;
    start_q.push_back('{k + 2, 4'b1000});
    wr(4'b0111);
    tick(10000);
    chk("long_active", 64'(bus_m.stat_active), 64'b1000);
    chk("long_timeout", 64'(bus_m.stat_timeout), 64'b0001);
    chk("long_clk_count", bus_m.clk_count, 64'(cyc - k - 1));
    chk("sat_clk_count", 64'(bus_s.clk_count), 64'd15);
    wr(4'b0111);
    tick(3);
    c = cyc;
    start_q.push_back('{c + 2, 4'b0100});
    bus_m.ctrl_wr     = 1'b1;
    bus_m.ctrl_init_n = 4'b0011;
    done(4'b1000, 4'b1000);
    bus_m.ctrl_wr     = 1'b0;
    bus_m.ctrl_init_n = 4'hF;
    chk("coin_active_gap", 64'(bus_m.stat_active), 64'h0);
    chk("coin_pass", 64'(bus_m.stat_pass), 64'b1010);
    chk("coin_clk_count", bus_m.clk_count, 64'(c - k));
    tick(1);
    chk("coin_ch2_active", 64'(bus_m.stat_active), 64'b0100);
    tick(2);
    done(4'b0100, 4'b0100);
    chk("coin_ch2_pass", 64'(bus_m.stat_pass), 64'b1110);
    chk("sat_clk_count_end", 64'(bus_s.clk_count), 64'd15);
    tick(2);

    // Reset with two channels active and one pending
    bus_m.tmo_limit = 32'd5;
    k = cyc;
    start_q.push_back('{k + 2, 4'b0011});
    wr(4'b1100);
    wr(4'b1011);
    chk("pre_rst_active", 64'(bus_m.stat_active), 64'b0011);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_active", 64'(bus_m.stat_active), 64'h0);
    chk("mid_rst_pass", 64'(bus_m.stat_pass), 64'h0);
    chk("mid_rst_fail", 64'(bus_m.stat_fail), 64'h0);
    chk("mid_rst_timeout", 64'(bus_m.stat_timeout), 64'h0);
    chk("mid_rst_clk_count", bus_m.clk_count, 64'h0);
    chk("mid_rst_pulses", 64'({bus_m.tg_start, bus_m.tg_abort}), 64'h0);
    rst_n = 1'b1;
    tick(20);
    chk("post_rst_active", 64'(bus_m.stat_active), 64'h0);
    chk("start_q_drained", 64'(start_q.size()), 64'h0);
    chk("abort_q_drained", 64'(abort_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
